// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU.
// Holds the default datapath widths, the 4-bit opcode map (including the
// halt opcode), the canonical NOP encoding, the fetch-stage state type and
// a helper that extracts the opcode field from a default-width instruction.
// Ports: none (package).
package cpu_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W       = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
  localparam logic [OPC_W-1:0] OP_LD  = 4'h8;
  localparam logic [OPC_W-1:0] OP_ST  = 4'h9;
  localparam logic [OPC_W-1:0] OP_BEQ = 4'hC;
  localparam logic [OPC_W-1:0] OP_JMP = 4'hD;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0000;

  // Fetch either runs freely or sits parked on a halt instruction.
  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

  // The opcode always lives in the top OPC_W bits of an instruction.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
    return instr[INSTR_W_DEF-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with a valid bit, sized for IF/ID but written
// so it can be reused between later stages.
// Ports:
//   clk     - clock, all state on rising edge
//   rst     - synchronous active-high reset (payload to FLUSH_VAL, valid 0)
//   load_i  - capture data_i/pc_i and mark the entry valid
//   flush_i - replace payload with FLUSH_VAL and clear valid (pc held)
//   kill_i  - clear valid only, payload held
//   data_i  - instruction payload in
//   pc_i    - associated PC value in
//   data_o  - registered payload
//   pc_o    - registered PC value
//   valid_o - entry holds a live instruction
module ifid_reg #(
  parameter int                 DATA_W    = 16,
  parameter int                 PC_W      = 16,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              kill_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   pc_q;
  logic              valid_q;

  // Controls are prioritised flush > kill > load; with none asserted the
  // entry simply holds, which is how an upstream stall is honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= FLUSH_VAL;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      data_q  <= FLUSH_VAL;
      valid_q <= 1'b0;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, steps
// the PC, takes branch redirects from decode, honours stalls and parks
// itself on a halt instruction until reset.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   stall         - decode not ready: hold PC and IF/ID
//   redirect      - taken branch/jump resolved in decode
//   redirect_pc   - target of that redirect
//   imem_addr     - instruction-memory address (always the current PC)
//   imem_rd_en    - instruction-memory read enable
//   imem_instr    - instruction returned combinationally for imem_addr
//   pc            - current PC
//   ifid_instr    - instruction buffered for decode
//   ifid_pc_next  - PC+PC_INC of the buffered instruction
//   ifid_valid    - buffered instruction is live
//   hlt           - halt latched, cleared only by reset
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                   ADDR_W     = ADDR_W_DEF,
  parameter int                   INSTR_W    = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter int                   PC_INC     = 1,
  parameter logic [OPC_W-1:0]     HLT_OPCODE = OP_HLT,
  parameter logic [INSTR_W-1:0]   NOP_INSTR  = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_next,
  output logic               ifid_valid,
  output logic               hlt
);

  logic [ADDR_W-1:0] pc_q;
  fetch_state_e      state_q;

  logic [ADDR_W-1:0] pcPlus;
  logic [OPC_W-1:0]  fetchOp;
  logic              fetchIsHalt;
  logic              doLoad;
  logic              doFlush;
  logic              doKill;

  // Sequential PC; wraps silently at the top of the address space.
  assign pcPlus      = pc_q + ADDR_W'(PC_INC);
  assign fetchOp     = imem_instr[INSTR_W-1 -: OPC_W];
  assign fetchIsHalt = (fetchOp == HLT_OPCODE);

  // IF/ID control decode, priority halt > redirect > stall > normal.
  // A redirect flushes the wrong-path fetch, and because it wins over the
  // normal path a halt opcode on the wrong path can never latch.
  always_comb begin
    doLoad  = 1'b0;
    doFlush = 1'b0;
    doKill  = 1'b0;
    if (state_q == FETCH_HALT) begin
      doKill = 1'b1;
    end else if (redirect) begin
      doFlush = 1'b1;
    end else if (!stall) begin
      doLoad = 1'b1;
    end
  end

  // PC register and run/halt state. On a halt fetch the PC stays on the
  // halt address so the debug view shows where execution stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else if (!stall) begin
            if (fetchIsHalt) begin
              state_q <= FETCH_HALT;
            end else begin
              pc_q <= pcPlus;
            end
          end
        end
        FETCH_HALT: begin
          pc_q    <= pc_q;
          state_q <= FETCH_HALT;
        end
        default: begin
          state_q <= FETCH_RUN;
        end
      endcase
    end
  end

  ifid_reg #(
    .DATA_W    (INSTR_W),
    .PC_W      (ADDR_W),
    .FLUSH_VAL (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (doLoad),
    .flush_i (doFlush),
    .kill_i  (doKill),
    .data_i  (imem_instr),
    .pc_i    (pcPlus),
    .data_o  (ifid_instr),
    .pc_o    (ifid_pc_next),
    .valid_o (ifid_valid)
  );

  // Memory read is suppressed while reset is asserted and once halted.
  assign imem_addr  = pc_q;
  assign imem_rd_en = ~rst & (state_q != FETCH_HALT);
  assign pc         = pc_q;
  assign hlt        = (state_q == FETCH_HALT);

endmodule
